dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/rv32i_types.sv | 27 ++
 rtl/dmem_bank.sv | 29 ++
 rtl/dmem_responder.sv | 103 ++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the data-memory responder: FSM state encoding, the request
// bundle seen from execute, and a byte-lane to bit-mask helper.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{lanes[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-addressed backing store with one combinational read port and one
// byte-masked synchronous write port sharing the same index.
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       wen,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset on purpose; contents must survive rst and a
    // reset branch would also prevent mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) begin
                mem[idx][b] <= wdata[8*b +: 8];
            end
        end
    end

    // The read sees the pre-edge contents, giving read-before-write on a shared index.
    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request in IDLE, commits
// writes immediately, and pulses dmem_resp exactly LATENCY cycles later.
module dmem_responder
    import rv32i_types::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be >= 1");
        end
        if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
            $error("dmem_responder: DEPTH_WORDS must be a power of two >= 4");
        end
    endgenerate

    dmem_req_t        req;
    state_e           state;
    logic [CNT_W-1:0] count;
    logic [31:0]      data_q;
    logic [31:0]      word;
    logic [31:0]      load_data;
    logic [3:0]       bank_wen;
    logic             accept;
    logic             unused_addr;

    assign req = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};

    // Only the word index is decoded; byte offset and high bits alias.
    assign unused_addr = ^req.addr;

    assign accept   = (state == IDLE) && ((req.rmask | req.wmask) != 4'b0);
    assign bank_wen = (accept && !rst) ? req.wmask : 4'b0;

    // A write (even with rmask set) answers with zero data; unread lanes are zero.
    assign load_data = (req.wmask != 4'b0) ? 32'b0 : (word & lane_mask(req.rmask));

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk  (clk),
        .wen  (bank_wen),
        .idx  (req.addr[2 +: IDX_W]),
        .wdata(req.wdata),
        .rdata(word)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            data_q     <= '0;
            dmem_resp  <= 1'b0;
            dmem_rdata <= '0;
        end else begin
            dmem_resp  <= 1'b0;
            dmem_rdata <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        count  <= CNT_W'(LATENCY - 1);
                        data_q <= load_data;
                        if (LATENCY > 1) begin
                            state <= BUSY;
                        end else begin
                            state      <= RESP;
                            dmem_resp  <= 1'b1;
                            dmem_rdata <= load_data;
                        end
                    end
                end
                BUSY: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state      <= RESP;
                        dmem_resp  <= 1'b1;
                        dmem_rdata <= data_q;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=1 instance for held back-to-back traffic.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  rmask, wmask;
    logic        resp;

    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_rmask, b_wmask;
    logic        b_resp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .dmem_addr (addr),
        .dmem_rmask(rmask),
        .dmem_wmask(wmask),
        .dmem_wdata(wdata),
        .dmem_rdata(rdata),
        .dmem_resp (resp)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .dmem_addr (b_addr),
        .dmem_rmask(b_rmask),
        .dmem_wmask(b_wmask),
        .dmem_wdata(b_wdata),
        .dmem_rdata(b_rdata),
        .dmem_resp (b_resp)
    );

    // Waits for the response of an already-driven request, then drops masks.
    task automatic wait_resp(output int lat, output logic [31:0] rd, output logic after);
        lat = -1;
        rd  = 32'hxxxx_xxxx;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp === 1'b1) begin
                lat = c;
                rd  = rdata;
                break;
            end
        end
        rmask = 4'b0;
        wmask = 4'b0;
        @(posedge clk);
        @(negedge clk);
        after = resp;
    endtask

    task automatic run_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output logic after);
        @(negedge clk);
        addr  = a;
        rmask = rm;
        wmask = wm;
        wdata = wd;
        wait_resp(lat, rd, after);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        addr = '0; rmask = '0; wmask = '0; wdata = '0;
        b_addr = '0; b_rmask = '0; b_wmask = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (resp !== 1'b0) begin failures++; $display("FAIL reset_resp got %b want 0", resp); end
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h want 0", rdata); end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (resp !== 1'b0) begin failures++; $display("FAIL idle_no_resp got %b want 0", resp); end
        end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic after;
        run_req(32'h100, 4'b0000, 4'b1111, 32'hDEADBEEF, lat, rd, after);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL sw_latency got %0d want 2", lat); end
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL sw_rdata got %h want 0", rd); end
        checks++;
        if (after !== 1'b0) begin failures++; $display("FAIL sw_single_pulse got %b want 0", after); end
        run_req(32'h100, 4'b1111, 4'b0000, 32'h0, lat, rd, after);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL lw_latency got %0d want 2", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got %h want deadbeef", rd); end
        checks++;
        if (after !== 1'b0) begin failures++; $display("FAIL lw_single_pulse got %b want 0", after); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rd; logic after;
        run_req(32'h40, 4'b0000, 4'b1111, 32'h11223344, lat, rd, after);
        run_req(32'h40, 4'b0000, 4'b0100, 32'h00AA0000, lat, rd, after);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL sb_rdata got %h want 0", rd); end
        run_req(32'h40, 4'b1111, 4'b0000, 32'h0, lat, rd, after);
        checks++;
        if (rd !== 32'h11AA3344) begin failures++; $display("FAIL sb_lw got %h want 11aa3344", rd); end
        run_req(32'h42, 4'b0100, 4'b0000, 32'h0, lat, rd, after);
        checks++;
        if (rd !== 32'h00AA0000) begin failures++; $display("FAIL lbu_lane2 got %h want 00aa0000", rd); end
        run_req(32'h40, 4'b0001, 4'b0000, 32'h0, lat, rd, after);
        checks++;
        if (rd !== 32'h00000044) begin failures++; $display("FAIL lbu_lane0 got %h want 00000044", rd); end
    endtask

    task automatic test_alias();
        int lat; logic [31:0] rd; logic after;
        run_req(32'h0000_1000, 4'b0000, 4'b1111, 32'h5, lat, rd, after);
        run_req(32'h0000_0000, 4'b1111, 4'b0000, 32'h0, lat, rd, after);
        checks++;
        if (rd !== 32'h5) begin failures++; $display("FAIL alias_rdata got %h want 5", rd); end
    endtask

    task automatic test_both_masks();
        int lat; logic [31:0] rd; logic after;
        run_req(32'h20, 4'b1111, 4'b1111, 32'h12345678, lat, rd, after);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL rw_latency got %0d want 2", lat); end
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rw_rdata got %h want 0", rd); end
        run_req(32'h20, 4'b1111, 4'b0000, 32'h0, lat, rd, after);
        checks++;
        if (rd !== 32'h12345678) begin failures++; $display("FAIL rw_lw got %h want 12345678", rd); end
    endtask

    task automatic test_reset_inflight();
        int lat; logic [31:0] rd; logic after;
        // Write accepted, then reset during its busy cycle: data must persist.
        @(negedge clk);
        addr = 32'h200; wmask = 4'b1111; rmask = 4'b0; wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; wmask = 4'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Load accepted, then reset during its busy cycle: no response may follow.
        addr = 32'h100; rmask = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (resp !== 1'b0) begin failures++; $display("FAIL busy_resp got %b want 0", resp); end
        rst = 1'b1; rmask = 4'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (resp !== 1'b0) begin failures++; $display("FAIL discarded_resp got %b want 0 (cycle %0d)", resp, c); end
            @(posedge clk);
            @(negedge clk);
        end
        // Request present in the very first cycle after reset deasserts.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        addr = 32'h100; rmask = 4'b1111; wmask = 4'b0;
        wait_resp(lat, rd, after);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL post_rst_latency got %0d want 2", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL post_rst_rdata got %h want deadbeef", rd); end
        run_req(32'h200, 4'b1111, 4'b0000, 32'h0, lat, rd, after);
        checks++;
        if (rd !== 32'h77) begin failures++; $display("FAIL write_kept got %h want 77", rd); end
    endtask

    task automatic test_back_to_back();
        logic want;
        @(negedge clk);
        b_addr = 32'h0; b_wmask = 4'b1111; b_rmask = 4'b0; b_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (b_resp !== 1'b1) begin failures++; $display("FAIL b2b_write_resp got %b want 1", b_resp); end
        b_wmask = 4'b0; b_rmask = 4'b1111;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            want = (c % 2 == 0);
            checks++;
            if (b_resp !== want) begin failures++; $display("FAIL b2b_pulse got %b want %b (cycle %0d)", b_resp, want, c); end
            if (want) begin
                checks++;
                if (b_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_rdata got %h want cafef00d", b_rdata); end
            end
        end
        b_rmask = 4'b0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_alias();
        test_both_masks();
        test_reset_inflight();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
